// File: rtl/ps2_rx.sv
// Host-side PS/2 receiver: synchronises and de-glitches the keyboard clock, deframes 11-bit frames.
// Define PS2_RX_EXT_EN to add E0/F0 prefix tracking on outputs ext and rel ('release' is a reserved word).
module ps2_rx #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] data,
   output logic       done,
   output logic       err,
   output logic       busy
`ifdef PS2_RX_EXT_EN
   ,
   output logic       ext,
   output logic       rel
`endif
);

   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    clkSync_q, datSync_q;
   logic          filtClk_q, filtClk_d;
   logic [FW-1:0] filtCnt_q, filtCnt_d;
   logic [TW-1:0] toCnt_q, toCnt_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parOk_q, parOk_d;
   logic          busy_q, busy_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          fe;
   logic          datBit;
`ifdef PS2_RX_EXT_EN
   logic          pendExt_q, pendExt_d;
   logic          pendRel_q, pendRel_d;
   logic          ext_q, ext_d;
   logic          rel_q, rel_d;
`endif

   assign datBit = datSync_q[1];

   // The filtered clock flips only after FILTER consecutive disagreeing samples.
   always_comb begin
      filtCnt_d = '0;
      filtClk_d = filtClk_q;
      if (clkSync_q[1] != filtClk_q) begin
         if (filtCnt_q == FW'(FILTER - 1)) filtClk_d = ~filtClk_q;
         else                             filtCnt_d = filtCnt_q + FW'(1);
      end
   end

   assign fe = filtClk_q & ~filtClk_d;

   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      shift_d  = shift_q;
      parOk_d  = parOk_q;
      busy_d   = busy_q;
      data_d   = data_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      toCnt_d  = '0;
`ifdef PS2_RX_EXT_EN
      pendExt_d = pendExt_q;
      pendRel_d = pendRel_q;
      ext_d     = ext_q;
      rel_d     = rel_q;
`endif
      if (busy_q && !fe) toCnt_d = toCnt_q + TW'(1);
      case (state_q)
         IDLE: if (fe) begin
            if (!datBit) begin
               state_d  = DATA;
               bitCnt_d = 3'd0;
               busy_d   = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         DATA: if (fe) begin
            shift_d  = {datBit, shift_q[7:1]};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_d = PARITY;
         end
         PARITY: if (fe) begin
            parOk_d = ^{shift_q, datBit};
            state_d = STOP;
         end
         STOP: if (fe) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (datBit && parOk_q) begin
`ifdef PS2_RX_EXT_EN
               // Prefix bytes are absorbed into the pending flags instead of being delivered.
               if (shift_q == 8'hE0) begin
                  pendExt_d = 1'b1;
               end else if (shift_q == 8'hF0) begin
                  pendRel_d = 1'b1;
               end else begin
                  data_d    = shift_q;
                  done_d    = 1'b1;
                  ext_d     = pendExt_q;
                  rel_d     = pendRel_q;
                  pendExt_d = 1'b0;
                  pendRel_d = 1'b0;
               end
`else
               data_d = shift_q;
               done_d = 1'b1;
`endif
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // An inter-edge gap this long means the keyboard gave up mid-frame.
      if (busy_q && !fe && toCnt_q == TW'(TIMEOUT - 1)) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         err_d   = 1'b1;
         toCnt_d = '0;
      end
`ifdef PS2_RX_EXT_EN
      if (err_d) begin
         pendExt_d = 1'b0;
         pendRel_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         clkSync_q <= 2'b11;
         datSync_q <= 2'b11;
         filtClk_q <= 1'b1;
         filtCnt_q <= '0;
         toCnt_q   <= '0;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parOk_q   <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef PS2_RX_EXT_EN
         pendExt_q <= 1'b0;
         pendRel_q <= 1'b0;
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clkSync_q <= {clkSync_q[0], ps2_clk};
         datSync_q <= {datSync_q[0], ps2_dat};
         filtClk_q <= filtClk_d;
         filtCnt_q <= filtCnt_d;
         toCnt_q   <= toCnt_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parOk_q   <= parOk_d;
         busy_q    <= busy_d;
         data_q    <= data_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef PS2_RX_EXT_EN
         pendExt_q <= pendExt_d;
         pendRel_q <= pendRel_d;
         ext_q     <= ext_d;
         rel_q     <= rel_d;
`endif
      end
   end

   assign data = data_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = busy_q;
`ifdef PS2_RX_EXT_EN
   assign ext  = ext_q;
   assign rel  = rel_q;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives whole and partial PS/2 frames and glitches, counts strobes on the
// falling clock edge, and compares against hand-computed expectations.
`timescale 1ns/1ps
module tb_ps2_rx;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 5000;
   localparam int HALF    = 125;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] data;
   logic       done, err, busy;
`ifdef PS2_RX_EXT_EN
   logic       ext, rel;
`endif

   int errors = 0;
   int checks = 0;
   int doneCnt = 0;
   int errCnt = 0;
   int bothCnt = 0;
   int busyCnt = 0;
   int d0, e0, b0;

   ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clock  (clock),
      .reset  (reset),
      .ps2_clk(ps2_clk),
      .ps2_dat(ps2_dat),
      .data   (data),
      .done   (done),
      .err    (err),
      .busy   (busy)
`ifdef PS2_RX_EXT_EN
      ,
      .ext    (ext),
      .rel    (rel)
`endif
   );

   always #20 clock = ~clock;

   // Strobes are tallied away from the active edge so every high cycle is seen exactly once.
   always @(negedge clock) begin
      if (done) doneCnt++;
      if (err) errCnt++;
      if (done && err) bothCnt++;
      if (busy) busyCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic sendBit(input logic b);
      ps2_dat = b;
      waitCycles(HALF);
      ps2_clk = 1'b0;
      waitCycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stop);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(par);
      sendBit(stop);
      ps2_dat = 1'b1;
      waitCycles(40);
   endtask

   task automatic snap();
      d0 = doneCnt;
      e0 = errCnt;
      b0 = busyCnt;
   endtask

   initial begin
      $display("[TB] ps2_rx directed test start");
      waitCycles(5);
      checkOutput("reset_data", 32'(data), 32'h00);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_err",  32'(err),  32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      waitCycles(20);

      snap();
      applyStimulus(8'h1C, 1'b0, 1'b1);
      checkOutput("good1C_done", 32'(doneCnt - d0), 32'd1);
      checkOutput("good1C_err",  32'(errCnt - e0),  32'd0);
      checkOutput("good1C_data", 32'(data), 32'h1C);
      checkOutput("good1C_busy", 32'(busy), 32'd0);

      snap();
      applyStimulus(8'h1C, 1'b1, 1'b1);
      checkOutput("badpar_err",  32'(errCnt - e0),  32'd1);
      checkOutput("badpar_done", 32'(doneCnt - d0), 32'd0);
      checkOutput("badpar_data", 32'(data), 32'h1C);

      snap();
      applyStimulus(8'h5A, 1'b1, 1'b0);
      checkOutput("badstop_err",  32'(errCnt - e0),  32'd1);
      checkOutput("badstop_done", 32'(doneCnt - d0), 32'd0);

`ifdef PS2_RX_EXT_EN
      snap();
      applyStimulus(8'hE0, 1'b0, 1'b1);
      applyStimulus(8'hF0, 1'b1, 1'b1);
      checkOutput("prefix_done", 32'(doneCnt - d0), 32'd0);
      applyStimulus(8'h75, 1'b0, 1'b1);
      checkOutput("ext75_done", 32'(doneCnt - d0), 32'd1);
      checkOutput("ext75_data", 32'(data), 32'h75);
      checkOutput("ext75_ext",  32'(ext), 32'd1);
      checkOutput("ext75_rel",  32'(rel), 32'd1);
      snap();
      applyStimulus(8'h5A, 1'b1, 1'b1);
      checkOutput("plain5A_ext", 32'(ext), 32'd0);
      checkOutput("plain5A_rel", 32'(rel), 32'd0);
`else
      snap();
      applyStimulus(8'h5A, 1'b1, 1'b1);
      checkOutput("b2b5A_data", 32'(data), 32'h5A);
      applyStimulus(8'hF0, 1'b1, 1'b1);
      checkOutput("b2bF0_data", 32'(data), 32'hF0);
      checkOutput("b2b_done",   32'(doneCnt - d0), 32'd2);
      checkOutput("b2b_err",    32'(errCnt - e0),  32'd0);
`endif

      snap();
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'b1);
      checkOutput("partial_busy", 32'(busy), 32'd1);
      waitCycles(TIMEOUT + 1000);
      checkOutput("timeout_err",  32'(errCnt - e0),  32'd1);
      checkOutput("timeout_done", 32'(doneCnt - d0), 32'd0);
      checkOutput("timeout_busy", 32'(busy), 32'd0);

      snap();
      applyStimulus(8'h29, 1'b0, 1'b1);
      checkOutput("after29_done", 32'(doneCnt - d0), 32'd1);
      checkOutput("after29_data", 32'(data), 32'h29);

      snap();
      for (int g = 0; g < 5; g++) begin
         ps2_clk = 1'b0;
         waitCycles(2);
         ps2_clk = 1'b1;
         waitCycles(20);
      end
      waitCycles(20);
      checkOutput("glitch_busy", 32'(busyCnt - b0), 32'd0);
      checkOutput("glitch_done", 32'(doneCnt - d0), 32'd0);
      checkOutput("glitch_err",  32'(errCnt - e0),  32'd0);

      snap();
      sendBit(1'b0);
      for (int i = 0; i < 3; i++) sendBit(1'b0);
      checkOutput("midframe_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      waitCycles(1);
      checkOutput("rst_data", 32'(data), 32'h00);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err",  32'(err),  32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      waitCycles(40);
      snap();
      applyStimulus(8'hA5, 1'b1, 1'b1);
      checkOutput("postrst_done", 32'(doneCnt - d0), 32'd1);
      checkOutput("postrst_data", 32'(data), 32'hA5);

      checkOutput("done_err_overlap", 32'(bothCnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
